// File: rtl/arch_map_retire_pkg.sv
// ---------------------------------------------------------------------------
// arch_map_retire_pkg
// Shared constants and types for the retire-side architectural map block.
//   COMMIT_WIDTH  : retire lanes per cycle (4)
//   NUM_LOG_REGS  : architectural registers (32 GPR + HI/LO)
//   LOG_W/PHYS_W  : logical / physical register index widths
//   state_t       : recovery-walk FSM state (IDLE / WALK)
//   retire_lane_t : one retiring instruction as seen by the AMT
// ---------------------------------------------------------------------------
package arch_map_retire_pkg;

    localparam int COMMIT_WIDTH = 4;
    localparam int NUM_LOG_REGS = 34;
    localparam int LOG_W        = 6;
    localparam int PHYS_W       = 7;

    // Highest legal logical index, pre-sized for comparisons against LOG_W buses.
    localparam logic [LOG_W-1:0] LAST_LOG_IDX = LOG_W'(NUM_LOG_REGS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              has_dest;
        logic [LOG_W-1:0]  log_dest;
        logic [PHYS_W-1:0] phy_dest;
    } retire_lane_t;

endpackage

// File: rtl/arch_map_retire_fwd.sv
// ---------------------------------------------------------------------------
// arch_map_retire_fwd
// Combinational old-mapping lookup for the four retire lanes.
//   busy     in  : recovery walk in progress; all lanes are squashed
//   lane     in  : retire lane descriptors, lane 0 is oldest
//   amt_rd   in  : committed AMT value at each lane's logical destination
//   active   out : lane retires with a destination this cycle
//   old_phys out : mapping being replaced by each lane (the register to free)
// A younger lane writing the same logical register as an older lane in the
// same group must free the older lane's new register, not the AMT value, so
// the youngest older matching lane overrides the AMT read.
// ---------------------------------------------------------------------------
module arch_map_retire_fwd
    import arch_map_retire_pkg::*;
(
    input  logic              busy,
    input  retire_lane_t      lane     [COMMIT_WIDTH],
    input  logic [PHYS_W-1:0] amt_rd   [COMMIT_WIDTH],
    output logic              active   [COMMIT_WIDTH],
    output logic [PHYS_W-1:0] old_phys [COMMIT_WIDTH]
);

    always_comb begin
        for (int n = 0; n < COMMIT_WIDTH; n++) begin
            active[n] = lane[n].valid & lane[n].has_dest & ~busy;
        end
        for (int n = 0; n < COMMIT_WIDTH; n++) begin
            old_phys[n] = amt_rd[n];
            // Ascending scan so the highest matching older lane wins.
            for (int m = 0; m < n; m++) begin
                if (active[m] && (lane[m].log_dest == lane[n].log_dest)) begin
                    old_phys[n] = lane[m].phy_dest;
                end
            end
        end
    end

endmodule

// File: rtl/arch_map_retire.sv
// ---------------------------------------------------------------------------
// arch_map_retire
// Architectural Map Table (logical -> committed physical register) on the
// retire side. Each retiring instruction with a destination frees the mapping
// it replaces (one cycle later, lane position preserved) and installs its own.
// On recovery the AMT is walked one entry per cycle to rebuild the rename map.
//
// Ports
//   clk, reset                       : clock, synchronous active-high reset
//   retValidN_i / retHasDestN_i      : lane N retiring / writes a register
//   retLogDestN_i / retPhyDestN_i    : lane N logical dest / new physical dest
//   recoverFlag_i                    : start (or restart) the recovery walk
//   commitValidN_o / commitRegN_o    : freed register for lane N (latency 1)
//   rmtWrEn_o/rmtWrAddr_o/rmtWrData_o: RMT restore write during the walk
//   busy_o                           : walk in progress, retires are ignored
//   freedCount_o (ARCH_MAP_RETIRE_PERF_EN only): running count of freed regs
//
// Build option: define ARCH_MAP_RETIRE_PERF_EN to add freedCount_o.
// ---------------------------------------------------------------------------
module arch_map_retire
    import arch_map_retire_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              retValid0_i,
    input  logic              retValid1_i,
    input  logic              retValid2_i,
    input  logic              retValid3_i,
    input  logic              retHasDest0_i,
    input  logic              retHasDest1_i,
    input  logic              retHasDest2_i,
    input  logic              retHasDest3_i,
    input  logic [LOG_W-1:0]  retLogDest0_i,
    input  logic [LOG_W-1:0]  retLogDest1_i,
    input  logic [LOG_W-1:0]  retLogDest2_i,
    input  logic [LOG_W-1:0]  retLogDest3_i,
    input  logic [PHYS_W-1:0] retPhyDest0_i,
    input  logic [PHYS_W-1:0] retPhyDest1_i,
    input  logic [PHYS_W-1:0] retPhyDest2_i,
    input  logic [PHYS_W-1:0] retPhyDest3_i,
    input  logic              recoverFlag_i,
    output logic              commitValid0_o,
    output logic              commitValid1_o,
    output logic              commitValid2_o,
    output logic              commitValid3_o,
    output logic [PHYS_W-1:0] commitReg0_o,
    output logic [PHYS_W-1:0] commitReg1_o,
    output logic [PHYS_W-1:0] commitReg2_o,
    output logic [PHYS_W-1:0] commitReg3_o,
    output logic              rmtWrEn_o,
    output logic [LOG_W-1:0]  rmtWrAddr_o,
    output logic [PHYS_W-1:0] rmtWrData_o,
    output logic              busy_o
`ifdef ARCH_MAP_RETIRE_PERF_EN
    ,
    output logic [31:0]       freedCount_o
`endif
);

    retire_lane_t      lane     [COMMIT_WIDTH];
    logic [PHYS_W-1:0] amt_rd   [COMMIT_WIDTH];
    logic              active   [COMMIT_WIDTH];
    logic [PHYS_W-1:0] old_phys [COMMIT_WIDTH];

    logic [PHYS_W-1:0] amt_reg  [NUM_LOG_REGS];

    logic              commit_valid_reg [COMMIT_WIDTH];
    logic [PHYS_W-1:0] commit_reg_reg   [COMMIT_WIDTH];

    state_t            state_reg, state_next;
    logic [LOG_W-1:0]  idx_reg, idx_next;

    assign lane[0] = '{valid: retValid0_i, has_dest: retHasDest0_i,
                       log_dest: retLogDest0_i, phy_dest: retPhyDest0_i};
    assign lane[1] = '{valid: retValid1_i, has_dest: retHasDest1_i,
                       log_dest: retLogDest1_i, phy_dest: retPhyDest1_i};
    assign lane[2] = '{valid: retValid2_i, has_dest: retHasDest2_i,
                       log_dest: retLogDest2_i, phy_dest: retPhyDest2_i};
    assign lane[3] = '{valid: retValid3_i, has_dest: retHasDest3_i,
                       log_dest: retLogDest3_i, phy_dest: retPhyDest3_i};

    // Logical indices above the last architectural register read as 0 rather
    // than indexing past the table.
    generate
        for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_amt_rd
            assign amt_rd[gi] = (lane[gi].log_dest <= LAST_LOG_IDX) ?
                                amt_reg[lane[gi].log_dest] : '0;
        end
    endgenerate

    arch_map_retire_fwd u_fwd (
        .busy     (busy_o),
        .lane     (lane),
        .amt_rd   (amt_rd),
        .active   (active),
        .old_phys (old_phys)
    );

    // AMT: lanes applied oldest first so the youngest writer of a register wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOG_REGS; i++) begin
                amt_reg[i] <= PHYS_W'(i);
            end
        end else begin
            for (int n = 0; n < COMMIT_WIDTH; n++) begin
                if (active[n] && (lane[n].log_dest <= LAST_LOG_IDX)) begin
                    amt_reg[lane[n].log_dest] <= lane[n].phy_dest;
                end
            end
        end
    end

    // Freed-register pipeline, one stage, no lane compaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < COMMIT_WIDTH; n++) begin
                commit_valid_reg[n] <= 1'b0;
                commit_reg_reg[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < COMMIT_WIDTH; n++) begin
                commit_valid_reg[n] <= active[n];
                commit_reg_reg[n]   <= active[n] ? old_phys[n] : '0;
            end
        end
    end

    assign commitValid0_o = commit_valid_reg[0];
    assign commitValid1_o = commit_valid_reg[1];
    assign commitValid2_o = commit_valid_reg[2];
    assign commitValid3_o = commit_valid_reg[3];
    assign commitReg0_o   = commit_reg_reg[0];
    assign commitReg1_o   = commit_reg_reg[1];
    assign commitReg2_o   = commit_reg_reg[2];
    assign commitReg3_o   = commit_reg_reg[3];

    // Recovery walk FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Recovery walk FSM: next state. A recover pulse mid-walk restarts at 0.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                idx_next = '0;
                if (recoverFlag_i) begin
                    state_next = WALK;
                end
            end
            WALK: begin
                if (recoverFlag_i) begin
                    idx_next = '0;
                end else if (idx_reg == LAST_LOG_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + LOG_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Recovery walk FSM: outputs. The AMT is frozen during WALK, so reading it
    // combinationally yields the committed state as of the recover pulse.
    always_comb begin
        busy_o      = 1'b0;
        rmtWrEn_o   = 1'b0;
        rmtWrAddr_o = '0;
        rmtWrData_o = '0;
        if (state_reg == WALK) begin
            busy_o      = 1'b1;
            rmtWrEn_o   = 1'b1;
            rmtWrAddr_o = idx_reg;
            rmtWrData_o = (idx_reg <= LAST_LOG_IDX) ? amt_reg[idx_reg] : '0;
        end
    end

`ifdef ARCH_MAP_RETIRE_PERF_EN
    logic [31:0] freed_count_reg;
    logic [2:0]  freed_inc;

    always_comb begin
        freed_inc = '0;
        for (int n = 0; n < COMMIT_WIDTH; n++) begin
            freed_inc = freed_inc + 3'(commit_valid_reg[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            freed_count_reg <= '0;
        end else begin
            freed_count_reg <= freed_count_reg + 32'(freed_inc);
        end
    end

    assign freedCount_o = freed_count_reg;
`endif

endmodule

// File: tb/tb_arch_map_retire.sv
// ---------------------------------------------------------------------------
// tb_arch_map_retire
// Self-checking bench for arch_map_retire. A behavioural model treats a retire
// group as a sequence of instructions applied one at a time to a plain array
// (old = map[d]; map[d] = new), and the recovery as a list of 34 writes.
// Directed groups follow the test plan, then randomized traffic with
// occasional recover pulses and resets. Define ARCH_MAP_RETIRE_PERF_EN to also
// check freedCount_o.
// ---------------------------------------------------------------------------
module tb_arch_map_retire;

    localparam int NL = 34;
    localparam int CW = 4;

    logic       clk;
    logic       reset;
    logic       recover;
    logic       ret_valid    [CW];
    logic       ret_has_dest [CW];
    logic [5:0] ret_log_dest [CW];
    logic [6:0] ret_phy_dest [CW];

    logic       commit_valid [CW];
    logic [6:0] commit_reg   [CW];
    logic       rmt_wr_en;
    logic [5:0] rmt_wr_addr;
    logic [6:0] rmt_wr_data;
    logic       busy;
`ifdef ARCH_MAP_RETIRE_PERF_EN
    logic [31:0] freed_count;
`endif

    arch_map_retire dut (
        .clk            (clk),
        .reset          (reset),
        .retValid0_i    (ret_valid[0]),
        .retValid1_i    (ret_valid[1]),
        .retValid2_i    (ret_valid[2]),
        .retValid3_i    (ret_valid[3]),
        .retHasDest0_i  (ret_has_dest[0]),
        .retHasDest1_i  (ret_has_dest[1]),
        .retHasDest2_i  (ret_has_dest[2]),
        .retHasDest3_i  (ret_has_dest[3]),
        .retLogDest0_i  (ret_log_dest[0]),
        .retLogDest1_i  (ret_log_dest[1]),
        .retLogDest2_i  (ret_log_dest[2]),
        .retLogDest3_i  (ret_log_dest[3]),
        .retPhyDest0_i  (ret_phy_dest[0]),
        .retPhyDest1_i  (ret_phy_dest[1]),
        .retPhyDest2_i  (ret_phy_dest[2]),
        .retPhyDest3_i  (ret_phy_dest[3]),
        .recoverFlag_i  (recover),
        .commitValid0_o (commit_valid[0]),
        .commitValid1_o (commit_valid[1]),
        .commitValid2_o (commit_valid[2]),
        .commitValid3_o (commit_valid[3]),
        .commitReg0_o   (commit_reg[0]),
        .commitReg1_o   (commit_reg[1]),
        .commitReg2_o   (commit_reg[2]),
        .commitReg3_o   (commit_reg[3]),
        .rmtWrEn_o      (rmt_wr_en),
        .rmtWrAddr_o    (rmt_wr_addr),
        .rmtWrData_o    (rmt_wr_data),
        .busy_o         (busy)
`ifdef ARCH_MAP_RETIRE_PERF_EN
        ,
        .freedCount_o   (freed_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---- bookkeeping -------------------------------------------------------
    int n_checks;
    int n_fails;
    int cycle_no;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL cycle %0d %s: got %0d expected %0d", cycle_no, tag, got, exp);
        end
    endtask

    // ---- behavioural model -------------------------------------------------
    int unsigned m_map [NL];          // committed mapping
    int unsigned m_wr_addr [$];       // pending restore writes, in order
    int unsigned m_wr_data [$];
    bit          m_free_v [CW];       // expected free outputs after this edge
    int unsigned m_free_r [CW];
    int unsigned m_count;             // expected freed-register counter

    task automatic model_identity();
        for (int i = 0; i < NL; i++) m_map[i] = i;
    endtask

    // Queue the full restore sequence as seen at the recover pulse.
    task automatic model_start_walk();
        m_wr_addr.delete();
        m_wr_data.delete();
        for (int i = 0; i < NL; i++) begin
            m_wr_addr.push_back(i);
            m_wr_data.push_back(m_map[i]);
        end
    endtask

    task automatic clear_lanes();
        for (int n = 0; n < CW; n++) begin
            ret_valid[n]    = 1'b0;
            ret_has_dest[n] = 1'b0;
            ret_log_dest[n] = '0;
            ret_phy_dest[n] = '0;
        end
    endtask

    task automatic set_lane(input int n, input bit v, input bit hd, input int ld, input int pd);
        ret_valid[n]    = v;
        ret_has_dest[n] = hd;
        ret_log_dest[n] = 6'(ld);
        ret_phy_dest[n] = 7'(pd);
    endtask

    // One clock: drive lanes (already set) plus recover/reset, predict, check.
    task automatic step(input bit rec, input bit rst);
        bit walking;
        int unsigned freed_now;
        int unsigned cur;
        walking = (m_wr_addr.size() != 0);

        // Counter accumulates the frees currently visible on the outputs.
        freed_now = 0;
        for (int n = 0; n < CW; n++) freed_now += m_free_v[n];
        m_count = m_count + freed_now;

        // The write visible now is consumed by this edge.
        if (walking) begin
            void'(m_wr_addr.pop_front());
            void'(m_wr_data.pop_front());
        end

        for (int n = 0; n < CW; n++) begin
            m_free_v[n] = 0;
            m_free_r[n] = 0;
        end
        if (!walking) begin
            for (int n = 0; n < CW; n++) begin
                if (ret_valid[n] && ret_has_dest[n]) begin
                    cur = ret_log_dest[n];
                    m_free_v[n] = 1;
                    m_free_r[n] = m_map[cur];
                    m_map[cur]  = ret_phy_dest[n];
                end
            end
        end

        if (rst) begin
            model_identity();
            m_wr_addr.delete();
            m_wr_data.delete();
            for (int n = 0; n < CW; n++) begin
                m_free_v[n] = 0;
                m_free_r[n] = 0;
            end
            m_count = 0;
        end else if (rec) begin
            model_start_walk();
        end

        recover = rec;
        reset   = rst;
        @(posedge clk);
        #1;
        cycle_no++;

        for (int n = 0; n < CW; n++) begin
            check_eq($sformatf("commitValid%0d", n), commit_valid[n], m_free_v[n]);
            check_eq($sformatf("commitReg%0d", n), commit_reg[n], m_free_r[n]);
        end
        walking = (m_wr_addr.size() != 0);
        check_eq("busy", busy, walking);
        check_eq("rmtWrEn", rmt_wr_en, walking);
        check_eq("rmtWrAddr", rmt_wr_addr, walking ? m_wr_addr[0] : 0);
        check_eq("rmtWrData", rmt_wr_data, walking ? m_wr_data[0] : 0);
`ifdef ARCH_MAP_RETIRE_PERF_EN
        check_eq("freedCount", freed_count, m_count);
`endif
        $display("cycle %0d rec=%0b rst=%0b busy=%0b rmt=%0b:%0d:%0d free=%0b%0b%0b%0b",
                 cycle_no, rec, rst, busy, rmt_wr_en, rmt_wr_addr, rmt_wr_data,
                 commit_valid[3], commit_valid[2], commit_valid[1], commit_valid[0]);

        recover = 1'b0;
        reset   = 1'b0;
        clear_lanes();
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0);
    endtask

    int busy_cycles;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        cycle_no = 0;
        m_count  = 0;
        for (int n = 0; n < CW; n++) begin
            m_free_v[n] = 0;
            m_free_r[n] = 0;
        end
        model_identity();
        recover = 1'b0;
        reset   = 1'b1;
        clear_lanes();

        // Reset state.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Single retire: 5 -> 40 frees 5.
        set_lane(0, 1, 1, 5, 40);
        step(1'b0, 1'b0);
        check_eq("plan1_reg0", commit_reg[0], 5);

        // Intra-group forwarding and a valid lane without a destination.
        set_lane(0, 1, 1, 3, 50);
        set_lane(1, 1, 0, 3, 99);
        set_lane(2, 1, 1, 3, 60);
        step(1'b0, 1'b0);
        check_eq("plan2_reg2", commit_reg[2], 50);

        // Four distinct destinations, then a full walk.
        set_lane(0, 1, 1, 1, 70);
        set_lane(1, 1, 1, 2, 71);
        set_lane(2, 1, 1, 4, 72);
        set_lane(3, 1, 1, 6, 73);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        busy_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            if (busy) busy_cycles++;
        end
        check_eq("busy_len", busy_cycles, NL);

        // Retire alongside the recover pulse, then retires during the walk.
        set_lane(0, 1, 1, 7, 80);
        step(1'b1, 1'b0);
        for (int i = 0; i < 36; i++) begin
            for (int n = 0; n < CW; n++)
                set_lane(n, 1, 1, $urandom_range(0, NL - 1), $urandom_range(0, 127));
            step(1'b0, 1'b0);
        end

        // Restart mid-walk at idx 10.
        step(1'b1, 1'b0);
        idle_steps(10);
        check_eq("restart_at", rmt_wr_addr, 10);
        step(1'b1, 1'b0);
        idle_steps(36);

        // Reset at idx 20, then walk the identity map.
        step(1'b1, 1'b0);
        idle_steps(20);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        idle_steps(35);

        // Frees of 4, 2, 1 registers accumulate to 7.
        step(1'b0, 1'b1);
        for (int n = 0; n < 4; n++) set_lane(n, 1, 1, 10 + n, 90 + n);
        step(1'b0, 1'b0);
        set_lane(1, 1, 1, 20, 100);
        set_lane(3, 1, 1, 21, 101);
        step(1'b0, 1'b0);
        set_lane(2, 1, 1, 22, 102);
        step(1'b0, 1'b0);
        idle_steps(2);
`ifdef ARCH_MAP_RETIRE_PERF_EN
        check_eq("perf_total", freed_count, 7);
`endif

        // Randomized traffic with small-index bias for collisions.
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < CW; n++) begin
                set_lane(n, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                         ($urandom_range(0, 1) != 0) ? $urandom_range(0, 5)
                                                     : $urandom_range(0, NL - 1),
                         $urandom_range(0, 127));
            end
            step($urandom_range(0, 39) == 0, $urandom_range(0, 249) == 0);
        end
        idle_steps(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
